timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter WIDTH, default 32, data and counter width in bits (8..32).
REQ-002 Parameter NCH, default 4, number of down-counter channels (1..8).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 addr  input  WIDTH  register address; only addr[4:0] decoded, upper bits ignored.
REQ-006 din  input  WIDTH  write data.
REQ-007 wen  input  1  write enable, effective only with cs.
REQ-008 cs  input  1  chip select.
REQ-009 dout  output  WIDTH  read data, combinational from addr, independent of cs.
REQ-010 irq  output  1  level interrupt request, active-high.

Function
REQ-011 Register map (addr[4:0]) SHALL be: 0 PRE; 1 CLOCK; 2 MODE (bit k = auto-reload for channel k); 3 STATUS (bit k = expiry flag k); 4 IE (bit k = interrupt enable k); 16+k CNT[k]; 24+k RLD[k]; k < NCH.
REQ-012 A write SHALL occur on a rising edge with cs=1, wen=1; writes to unmapped addresses or to bits at or above NCH in MODE/STATUS/IE SHALL be ignored.
REQ-013 Reads of unmapped addresses, and of MODE/STATUS/IE bits at or above NCH, SHALL return 0.
REQ-014 Prescaler counter precnt SHALL count 0..PRE while PRE != 0 and SHALL hold at 0 while PRE = 0.
REQ-015 tick SHALL be 1 for one cycle when PRE != 0 and precnt == PRE; precnt SHALL then return to 0, giving one tick every PRE+1 cycles.
REQ-016 A write to PRE SHALL load PRE and clear precnt in the same edge, and no tick SHALL occur on that edge.
REQ-017 CLOCK SHALL increment by 1 mod 2^WIDTH on each tick; a CLOCK write on the same edge SHALL take priority and load din.
REQ-018 On tick with CNT[k] > 1, CNT[k] SHALL decrement by 1.
REQ-019 On tick with CNT[k] == 1, STATUS[k] SHALL be set and CNT[k] SHALL load RLD[k] if MODE[k] = 1, else 0.
REQ-020 On tick with CNT[k] == 0, CNT[k] SHALL hold and no flag SHALL be set (stopped channel).
REQ-021 A CPU write to CNT[k] SHALL take priority over a tick on the same edge and SHALL NOT set STATUS[k].
REQ-022 Writing STATUS SHALL clear each bit written as 1 (W1C); a same-edge set from REQ-019 SHALL win over the clear.
REQ-023 RLD[k] writes SHALL NOT affect CNT[k] until the next reload; MODE[k]=1 with RLD[k]=0 SHALL stop the channel at 0 after expiry.
REQ-024 irq SHALL equal OR over k of (STATUS[k] AND IE[k]), so it asserts in the cycle after the expiring tick edge.

Reset
REQ-025 On reset, PRE, precnt, CLOCK, MODE, STATUS, IE, every CNT[k] and every RLD[k] SHALL become 0.
REQ-026 While reset is 1, writes and ticks SHALL be ignored; irq SHALL be 0 from the first edge with reset=1.
REQ-027 Reset asserted mid-count SHALL abandon the count; no flag SHALL be set by the aborted expiry.

Configuration
REQ-028 Macro TIMER_BANK_IRQ_EN defined: IE register, irq generation per REQ-024 SHALL be present.
REQ-029 Macro TIMER_BANK_IRQ_EN undefined: IE SHALL read 0 and ignore writes, irq SHALL be tied 0, STATUS SHALL still operate.

Verification
REQ-030 PRE=4, CLOCK=0, run 25 cycles -> CLOCK=5, ticks exactly every 5 cycles.
REQ-031 PRE=1, CNT[0]=3, MODE=0 -> STATUS[0]=1 after 3rd tick, CNT[0]=0 thereafter, irq=1 only with IE[0]=1.
REQ-032 PRE=1, RLD[1]=2, CNT[1]=2, MODE[1]=1 -> STATUS[1] sets every 2 ticks, CNT[1] cycles 2,1,2,1.
REQ-033 W1C to STATUS[0] on the same edge as channel 0 expiry -> STATUS[0] remains 1; W1C next cycle -> 0, irq drops.
REQ-034 CNT[2] write coinciding with a tick -> CNT[2]=din, no decrement, no flag; PRE write resets precnt.
REQ-035 reset pulse mid-count with PRE=3, CNT[0]=5 -> all registers read 0, irq=0, no flag afterwards.

Source files
------------

// File: rtl/timer_bank_if.sv
// CPU register port of the timer bank: address/data/strobes in, read data and irq out.
// Purely a signal bundle; no state, no handshake beyond cs/wen.
interface timer_bank_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             wen;
    logic             cs;
    logic             irq;

    modport master (
        output addr,
        output din,
        output wen,
        output cs,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  din,
        input  wen,
        input  cs,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_bank.sv
// Prescaled free-running CLOCK plus NCH down-counters with W1C expiry flags; TIMER_BANK_IRQ_EN adds IE/irq.
// Latency: writes land on the clk edge with cs&wen; dout is combinational from addr; irq follows flags by one edge.
// Backpressure: none -- every access completes in the cycle it is presented.
module timer_bank #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    timer_bank_if.slave bus
);

    localparam logic [4:0] A_PRE    = 5'd0;
    localparam logic [4:0] A_CLOCK  = 5'd1;
    localparam logic [4:0] A_MODE   = 5'd2;
    localparam logic [4:0] A_STATUS = 5'd3;
    localparam logic [4:0] A_IE     = 5'd4;

    logic [4:0]       w_addr;
    logic             w_we;
    logic             w_unused_addr;

    logic [WIDTH-1:0] r_pre;
    logic [WIDTH-1:0] r_precnt;
    logic [WIDTH-1:0] r_clock;
    logic [NCH-1:0]   r_mode;
    logic [NCH-1:0]   r_status;
    logic [WIDTH-1:0] r_cnt [NCH];
    logic [WIDTH-1:0] r_rld [NCH];

    logic             w_wr_pre;
    logic             w_wr_clock;
    logic             w_wr_mode;
    logic             w_wr_status;
    logic [NCH-1:0]   w_wr_cnt;
    logic [NCH-1:0]   w_wr_rld;
    logic             w_tick;
    logic [NCH-1:0]   w_expire;
    logic [NCH-1:0]   w_clr;
    logic [WIDTH-1:0] w_rdata;

    assign w_addr        = bus.addr[4:0];
    assign w_unused_addr = ^bus.addr[WIDTH-1:5];
    assign w_we          = bus.cs & bus.wen;

    assign w_wr_pre    = w_we && (w_addr == A_PRE);
    assign w_wr_clock  = w_we && (w_addr == A_CLOCK);
    assign w_wr_mode   = w_we && (w_addr == A_MODE);
    assign w_wr_status = w_we && (w_addr == A_STATUS);

    always_comb begin
        w_wr_cnt = '0;
        w_wr_rld = '0;
        for (int k = 0; k < NCH; k++) begin
            w_wr_cnt[k] = w_we && (w_addr == 5'(16 + k));
            w_wr_rld[k] = w_we && (w_addr == 5'(24 + k));
        end
    end

    // A PRE write restarts the prescaler, so it must also swallow the tick due on that edge.
    assign w_tick = (r_pre != '0) && (r_precnt == r_pre) && !w_wr_pre;

    // A CPU write to CNT[k] overrides the tick, including the expiry it would have caused.
    always_comb begin
        w_expire = '0;
        for (int k = 0; k < NCH; k++) begin
            w_expire[k] = w_tick && !w_wr_cnt[k] && (r_cnt[k] == WIDTH'(1));
        end
    end

    assign w_clr = w_wr_status ? bus.din[NCH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre    <= '0;
            r_precnt <= '0;
            r_clock  <= '0;
        end else begin
            if (w_wr_pre) begin
                r_pre    <= bus.din;
                r_precnt <= '0;
            end else if ((r_pre == '0) || (r_precnt == r_pre)) begin
                r_precnt <= '0;
            end else begin
                r_precnt <= r_precnt + WIDTH'(1);
            end

            if (w_wr_clock) begin
                r_clock <= bus.din;
            end else if (w_tick) begin
                r_clock <= r_clock + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode   <= '0;
            r_status <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_cnt[k] <= '0;
                r_rld[k] <= '0;
            end
        end else begin
            if (w_wr_mode) begin
                r_mode <= bus.din[NCH-1:0];
            end
            // Set beats W1C so an expiry coinciding with a clear is never lost.
            r_status <= (r_status & ~w_clr) | w_expire;

            for (int k = 0; k < NCH; k++) begin
                if (w_wr_rld[k]) begin
                    r_rld[k] <= bus.din;
                end
                if (w_wr_cnt[k]) begin
                    r_cnt[k] <= bus.din;
                end else if (w_tick) begin
                    if (r_cnt[k] > WIDTH'(1)) begin
                        r_cnt[k] <= r_cnt[k] - WIDTH'(1);
                    end else if (r_cnt[k] == WIDTH'(1)) begin
                        r_cnt[k] <= r_mode[k] ? r_rld[k] : '0;
                    end
                end
            end
        end
    end

`ifdef TIMER_BANK_IRQ_EN
    logic [NCH-1:0] r_ie;
    logic           w_wr_ie;

    assign w_wr_ie = w_we && (w_addr == A_IE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie <= '0;
        end else if (w_wr_ie) begin
            r_ie <= bus.din[NCH-1:0];
        end
    end

    assign bus.irq = |(r_status & r_ie);
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_PRE:    w_rdata = r_pre;
            A_CLOCK:  w_rdata = r_clock;
            A_MODE:   w_rdata[NCH-1:0] = r_mode;
            A_STATUS: w_rdata[NCH-1:0] = r_status;
`ifdef TIMER_BANK_IRQ_EN
            A_IE:     w_rdata[NCH-1:0] = r_ie;
`endif
            default: begin
                for (int k = 0; k < NCH; k++) begin
                    if (w_addr == 5'(16 + k)) begin
                        w_rdata = r_cnt[k];
                    end else if (w_addr == 5'(24 + k)) begin
                        w_rdata = r_rld[k];
                    end
                end
            end
        endcase
    end

    assign bus.dout = w_rdata;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank (WIDTH=32, NCH=4): register-map table plus timed sequences for ticks, expiry, W1C and reset.
module tb_timer_bank;

    localparam logic [31:0] A_PRE    = 32'd0;
    localparam logic [31:0] A_CLOCK  = 32'd1;
    localparam logic [31:0] A_MODE   = 32'd2;
    localparam logic [31:0] A_STATUS = 32'd3;
    localparam logic [31:0] A_IE     = 32'd4;
    localparam logic [31:0] A_CNT0   = 32'd16;
    localparam logic [31:0] A_RLD0   = 32'd24;

`ifdef TIMER_BANK_IRQ_EN
    localparam bit          IRQ_ON = 1'b1;
    localparam logic [31:0] IE_EXP = 32'h0000_000F;
`else
    localparam bit          IRQ_ON = 1'b0;
    localparam logic [31:0] IE_EXP = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    timer_bank_if #(.WIDTH(32)) bus ();

    timer_bank #(.WIDTH(32), .NCH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        string       tag;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [31:0] e, string tag);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.e = e; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.cs   = 1'b1;
        bus.wen  = 1'b1;
        @(posedge clk);
        #1;
        bus.cs  = 1'b0;
        bus.wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addr = a;
        #1;
        chk(tag_q.pop_front(), bus.dout, exp_q.pop_front());
    endtask

    task automatic chk_irq(input bit exp, input string tag);
        chk(tag, {31'b0, bus.irq}, {31'b0, exp});
    endtask

    task automatic do_reset();
        bus.cs  = 1'b0;
        bus.wen = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.addr = '0;
        bus.din  = '0;
        bus.cs   = 1'b0;
        bus.wen  = 1'b0;
        reset    = 1'b1;

        // Register map, masking and address decode; PRE stays 0 so nothing ticks.
        vecs.push_back(mk(0, A_PRE,        0, 0, "rst_pre"));
        vecs.push_back(mk(0, A_CLOCK,      0, 0, "rst_clock"));
        vecs.push_back(mk(0, A_MODE,       0, 0, "rst_mode"));
        vecs.push_back(mk(0, A_STATUS,     0, 0, "rst_status"));
        vecs.push_back(mk(0, A_IE,         0, 0, "rst_ie"));
        vecs.push_back(mk(0, A_CNT0,       0, 0, "rst_cnt0"));
        vecs.push_back(mk(0, A_CNT0 + 3,   0, 0, "rst_cnt3"));
        vecs.push_back(mk(0, A_RLD0 + 3,   0, 0, "rst_rld3"));
        vecs.push_back(mk(1, A_MODE,       32'hFF, 0, ""));
        vecs.push_back(mk(0, A_MODE,       0, 32'h0F, "mode_mask"));
        vecs.push_back(mk(1, A_IE,         32'hFF, 0, ""));
        vecs.push_back(mk(0, A_IE,         0, IE_EXP, "ie_mask"));
        vecs.push_back(mk(1, A_STATUS,     32'hF, 0, ""));
        vecs.push_back(mk(0, A_STATUS,     0, 0, "status_w1c_idle"));
        vecs.push_back(mk(1, A_RLD0,       32'hDEAD_BEEF, 0, ""));
        vecs.push_back(mk(0, A_RLD0,       0, 32'hDEAD_BEEF, "rld0_rb"));
        vecs.push_back(mk(0, 32'h0000_0118, 0, 32'hDEAD_BEEF, "rld0_hi_addr"));
        vecs.push_back(mk(1, A_RLD0 + 3,   32'h1234_5678, 0, ""));
        vecs.push_back(mk(0, A_RLD0 + 3,   0, 32'h1234_5678, "rld3_rb"));
        vecs.push_back(mk(1, A_CNT0 + 1,   32'd7, 0, ""));
        vecs.push_back(mk(0, A_CNT0 + 1,   0, 32'd7, "cnt1_rb"));
        vecs.push_back(mk(1, 32'd5,        32'hAAAA, 0, ""));
        vecs.push_back(mk(0, 32'd5,        0, 0, "unmapped5"));
        vecs.push_back(mk(0, 32'd20,       0, 0, "unmapped_cnt4"));
        vecs.push_back(mk(0, 32'd28,       0, 0, "unmapped_rld4"));
        vecs.push_back(mk(0, 32'd31,       0, 0, "unmapped31"));
        vecs.push_back(mk(0, A_PRE,        0, 0, "pre_untouched"));
        vecs.push_back(mk(1, 32'h0000_0FE1, 32'h55, 0, ""));
        vecs.push_back(mk(0, A_CLOCK,      0, 32'h55, "clock_hi_addr_wr"));

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].w) begin
                wr(vecs[i].a, vecs[i].d);
            end else begin
                rd(vecs[i].a, vecs[i].e, vecs[i].tag);
                idle(1);
            end
        end
        chk_irq(1'b0, "table_irq");

        // PRE=4: CLOCK advances once every 5 edges.
        do_reset();
        wr(A_CLOCK, 0);
        wr(A_PRE, 4);
        for (int c = 1; c <= 25; c++) begin
            idle(1);
            rd(A_CLOCK, 32'(c / 5), $sformatf("clock_c%0d", c));
        end

        // One-shot channel 0 expiring on the 3rd tick.
        do_reset();
        wr(A_IE, 1);
        wr(A_CNT0, 3);
        wr(A_PRE, 1);
        idle(5);
        rd(A_CNT0, 1, "os_cnt_pre");
        rd(A_STATUS, 0, "os_status_pre");
        chk_irq(1'b0, "os_irq_pre");
        idle(1);
        rd(A_STATUS, 1, "os_status_exp");
        rd(A_CNT0, 0, "os_cnt_exp");
        chk_irq(IRQ_ON, "os_irq_exp");
        idle(4);
        rd(A_CNT0, 0, "os_cnt_stopped");
        wr(A_STATUS, 1);
        rd(A_STATUS, 0, "os_status_clr");
        chk_irq(1'b0, "os_irq_clr");
        wr(A_IE, 0);
        wr(A_CNT0, 1);
        idle(3);
        rd(A_STATUS, 1, "os_status_noie");
        chk_irq(1'b0, "os_irq_noie");

        // Auto-reload channel 1 with RLD=2, then RLD=0 stops it after expiry.
        do_reset();
        wr(A_RLD0 + 1, 2);
        wr(A_MODE, 2);
        wr(A_CNT0 + 1, 2);
        wr(A_PRE, 1);
        idle(1); rd(A_CNT0 + 1, 2, "ar_cnt_p1");
        idle(1); rd(A_CNT0 + 1, 1, "ar_cnt_p2");
        idle(1); rd(A_CNT0 + 1, 1, "ar_cnt_p3");
        rd(A_STATUS, 0, "ar_status_p3");
        idle(1); rd(A_CNT0 + 1, 2, "ar_cnt_p4");
        rd(A_STATUS, 2, "ar_status_p4");
        wr(A_STATUS, 2);
        rd(A_STATUS, 0, "ar_status_p5");
        idle(1); rd(A_CNT0 + 1, 1, "ar_cnt_p6");
        idle(2); rd(A_CNT0 + 1, 2, "ar_cnt_p8");
        rd(A_STATUS, 2, "ar_status_p8");
        wr(A_STATUS, 2);
        wr(A_RLD0 + 1, 0);
        rd(A_CNT0 + 1, 1, "ar_cnt_p10");
        idle(2);
        rd(A_CNT0 + 1, 0, "ar_cnt_rld0");
        rd(A_STATUS, 2, "ar_status_rld0");
        wr(A_STATUS, 2);
        idle(4);
        rd(A_CNT0 + 1, 0, "ar_cnt_held");
        rd(A_STATUS, 0, "ar_status_held");

        // W1C colliding with expiry: the set survives.
        do_reset();
        wr(A_IE, 1);
        wr(A_CNT0, 2);
        wr(A_PRE, 1);
        idle(3);
        rd(A_STATUS, 0, "w1c_status_pre");
        wr(A_STATUS, 1);
        rd(A_STATUS, 1, "w1c_same_edge");
        chk_irq(IRQ_ON, "w1c_irq_kept");
        wr(A_STATUS, 1);
        rd(A_STATUS, 0, "w1c_next_edge");
        chk_irq(1'b0, "w1c_irq_drop");

        // CNT write on a tick edge, and PRE write swallowing a due tick.
        do_reset();
        wr(A_CNT0 + 2, 5);
        wr(A_PRE, 1);
        idle(1);
        wr(A_CNT0 + 2, 1);
        rd(A_CNT0 + 2, 1, "cw_cnt_wins");
        rd(A_STATUS, 0, "cw_no_flag");
        idle(1);
        rd(A_CNT0 + 2, 1, "cw_cnt_hold");
        idle(1);
        rd(A_CNT0 + 2, 0, "cw_cnt_exp");
        rd(A_STATUS, 4, "cw_status_exp");
        wr(A_CNT0 + 2, 10);
        wr(A_PRE, 3);
        rd(A_CNT0 + 2, 10, "pw_no_tick");
        idle(3);
        rd(A_CNT0 + 2, 10, "pw_precnt_restart");
        idle(1);
        rd(A_CNT0 + 2, 9, "pw_first_tick");

        // CLOCK wraps, and a CLOCK write beats the tick.
        do_reset();
        wr(A_CLOCK, 32'hFFFF_FFFF);
        wr(A_PRE, 1);
        idle(2);
        rd(A_CLOCK, 0, "clock_wrap");
        idle(1);
        wr(A_CLOCK, 50);
        rd(A_CLOCK, 50, "clock_wr_wins");
        idle(2);
        rd(A_CLOCK, 51, "clock_after_wr");

        // Reset mid-count abandons everything; writes during reset are dropped.
        do_reset();
        wr(A_PRE, 3);
        wr(A_CNT0, 5);
        wr(A_CNT0 + 1, 1);
        wr(A_IE, 32'hF);
        wr(A_MODE, 1);
        wr(A_RLD0, 7);
        idle(2);
        rd(A_STATUS, 2, "rm_status_pre");
        rd(A_CNT0, 4, "rm_cnt_pre");
        chk_irq(IRQ_ON, "rm_irq_pre");
        reset    = 1'b1;
        bus.addr = A_PRE;
        bus.din  = 32'd9;
        bus.cs   = 1'b1;
        bus.wen  = 1'b1;
        @(posedge clk);
        #1;
        chk_irq(1'b0, "rm_irq_first_edge");
        @(posedge clk);
        #1;
        bus.cs  = 1'b0;
        bus.wen = 1'b0;
        reset   = 1'b0;
        rd(A_PRE, 0, "rm_pre");
        rd(A_CLOCK, 0, "rm_clock");
        rd(A_MODE, 0, "rm_mode");
        rd(A_STATUS, 0, "rm_status");
        rd(A_IE, 0, "rm_ie");
        rd(A_CNT0, 0, "rm_cnt0");
        rd(A_CNT0 + 1, 0, "rm_cnt1");
        rd(A_RLD0, 0, "rm_rld0");
        chk_irq(1'b0, "rm_irq");
        idle(30);
        rd(A_STATUS, 0, "rm_status_later");
        rd(A_CNT0, 0, "rm_cnt0_later");
        rd(A_CLOCK, 0, "rm_clock_later");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
